mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 32x8 data memory between an instruction-fetch
//  requester (read-only) and a data requester (read/write).
//  Round-robin arbitration; one access in flight; registered read data.
//  Sits between the CPU control/datapath and the memory instance.
//  Drives the memory's write_enable/address/write_data; memory writes on negedge clk.
// PARAMETERS
//  ADDR_W  5  memory address width
//  DATA_W  8  memory data width
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst_n      in   1       synchronous reset, active-low
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch request accepted this cycle
//  if_rdata   out  DATA_W  fetch read data, valid with if_rvalid
//  if_rvalid  out  1       one-cycle fetch response strobe
//  dm_req     in   1       data request; held with dm_we/addr/wdata until dm_gnt
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  write data
//  dm_gnt     out  1       data request accepted this cycle
//  dm_rdata   out  DATA_W  data read data, valid with dm_rvalid
//  dm_rvalid  out  1       one-cycle data response (read data or write ack)
//  mem_we     out  1       to memory write_enable
//  mem_addr   out  ADDR_W  to memory address
//  mem_wdata  out  DATA_W  to memory write_data
//  mem_rdata  in   DATA_W  from memory read_data (combinational)
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, last_winner=DM (IF wins first tie),
//   mem_we/mem_addr/mem_wdata=0, if_/dm_rdata=0, if_/dm_rvalid=0.
//   While rst_n low, if_gnt=dm_gnt=0 (combinationally gated).
//  FSM states: IDLE, ACCESS.
//  IDLE: gnt combinational from req; at most one gnt high.
//   Only one req -> grant it. Both -> grant port not equal last_winner.
//   On gnt: posedge latches addr/we/wdata into mem_* regs, records winner,
//   updates last_winner, -> ACCESS. No req -> stay IDLE, mem_we=0.
//  ACCESS: mem_we = latched we (IF always 0); memory commits write at mid-cycle negedge.
//   gnt outputs 0. At posedge: capture mem_rdata into winner's rdata,
//   pulse winner's rvalid for exactly the next cycle, -> IDLE.
//  Latency: gnt in cycle N, memory access cycle N+1, rvalid in cycle N+2.
//  Throughput: one access per 2 cycles; response cycle overlaps next IDLE grant.
//  Write: dm_rvalid still pulses as ack; dm_rdata = mem_rdata at the written
//   address after the negedge write (i.e. the new value).
//  mem_addr/mem_wdata hold last latched values outside ACCESS; mem_we=0 outside ACCESS.
//  Non-winner rdata registers hold their previous value.
//  Requester dropping req before gnt: no access, no rvalid, last_winner unchanged.
//  Reset sampled during ACCESS: negedge write already committed; rvalid suppressed;
//   -> IDLE with reset values.
//  Address wraps naturally within ADDR_W; no range checks.
// TESTING
//  T1 reset: rst_n=0 two cycles with if_req=dm_req=1 -> gnts 0, mem_we 0, rvalids 0.
//  T2 fetch only: mem[3]=8'hA5, if_req addr=3 -> if_gnt cyc N, if_rvalid cyc N+2, if_rdata=8'hA5.
//  T3 data write then read: write 8'h3C to addr 31 -> dm_rvalid ack, mem_we high only in
//     ACCESS; then read addr 31 -> dm_rdata=8'h3C.
//  T4 contention: both req held 6 cycles after reset -> grants IF,DM,IF alternating,
//     one gnt per 2 cycles, never both high.
//  T5 write/read hazard: DM writes 8'h77 to addr 5 while IF requests addr 5 -> whichever
//     is served second returns 8'h77.
//  T6 reset mid-ACCESS of DM write 8'h11 to addr 2 -> no dm_rvalid; mem[2]=8'h11; state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory port.
// The arbiter takes the slave view; the surrounding CPU/memory glue takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_rvalid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port data memory between instruction fetch
// (read-only) and data (read/write) requesters, one access in flight.
//
// state    | meaning
// S_IDLE   | grants issued combinationally; winner's request latched at posedge
// S_ACCESS | memory driven with latched request; read data captured at posedge
module mem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        state;
  logic              last_dm;
  logic              win_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic              if_gnt;
  logic              dm_gnt;

  // On a tie the port that did not win last time is served.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      if (bus.if_req && bus.dm_req) begin
        if_gnt = last_dm;
        dm_gnt = ~last_dm;
      end else begin
        if_gnt = bus.if_req;
        dm_gnt = bus.dm_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_dm     <= 1'b1;
      win_dm      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_gnt || dm_gnt) begin
            addr_q  <= dm_gnt ? bus.dm_addr : bus.if_addr;
            we_q    <= dm_gnt & bus.dm_we;
            if (dm_gnt) wdata_q <= bus.dm_wdata;
            win_dm  <= dm_gnt;
            last_dm <= dm_gnt;
            state   <= S_ACCESS;
          end
        end
        default: begin
          // A write has already landed on the negedge, so this returns the new value.
          if (win_dm) begin
            dm_rdata_q  <= bus.mem_rdata;
            dm_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q  <= bus.mem_rdata;
            if_rvalid_q <= 1'b1;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.mem_we    = (state == S_ACCESS) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed hazard/reset sequences and
// random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] init_val(input int i);
    if (i == 3) return 8'hA5;
    return 8'(i * 13 + 7);
  endfunction

  // Memory instance: combinational read, write on negedge.
  logic [7:0] tb_mem [32];
  assign bus.mem_rdata = tb_mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory image, who is owed a response and when.
  logic [7:0] ref_mem [32];
  int         cyc = 0;
  bit         m_known = 0;
  bit         m_busy = 0;
  bit         m_last_dm = 1;
  bit         m_acc_we = 0;
  logic [4:0] m_mem_addr = '0;
  logic [7:0] m_acc_wdata = '0;
  bit         m_pend = 0;
  bit         m_pend_dm = 0;
  logic [7:0] m_pend_data = '0;
  int         m_due = 0;
  logic [7:0] m_if_rdata = '0;
  logic [7:0] m_dm_rdata = '0;

  logic       s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mem_we;
  logic [7:0] s_if_rdata, s_dm_rdata;

  task automatic tick();
    bit e_ig, e_dg, e_ir, e_dr, we;
    logic [4:0] a;
    @(negedge clk);
    #3;
    s_if_gnt   = bus.if_gnt;
    s_dm_gnt   = bus.dm_gnt;
    s_if_rv    = bus.if_rvalid;
    s_dm_rv    = bus.dm_rvalid;
    s_mem_we   = bus.mem_we;
    s_if_rdata = bus.if_rdata;
    s_dm_rdata = bus.dm_rdata;

    e_ig = 0;
    e_dg = 0;
    if (rst_n && !m_busy) begin
      if (bus.if_req && bus.dm_req) begin
        e_ig = m_last_dm;
        e_dg = !m_last_dm;
      end else begin
        e_ig = bus.if_req;
        e_dg = bus.dm_req;
      end
    end
    e_ir = m_pend && (m_due == cyc) && !m_pend_dm;
    e_dr = m_pend && (m_due == cyc) && m_pend_dm;
    if (e_ir) m_if_rdata = m_pend_data;
    if (e_dr) m_dm_rdata = m_pend_data;

    chk("model_if_gnt", 32'(s_if_gnt), 32'(e_ig));
    chk("model_dm_gnt", 32'(s_dm_gnt), 32'(e_dg));
    if (m_known) begin
      chk("model_if_rvalid", 32'(s_if_rv), 32'(e_ir));
      chk("model_dm_rvalid", 32'(s_dm_rv), 32'(e_dr));
      chk("model_mem_we", 32'(s_mem_we), 32'(m_busy && m_acc_we));
      chk("model_if_rdata", 32'(s_if_rdata), 32'(m_if_rdata));
      chk("model_dm_rdata", 32'(s_dm_rdata), 32'(m_dm_rdata));
      chk("model_mem_addr", 32'(bus.mem_addr), 32'(m_mem_addr));
      if (m_busy && m_acc_we) chk("model_mem_wdata", 32'(bus.mem_wdata), 32'(m_acc_wdata));
    end

    if (m_pend && (m_due == cyc)) m_pend = 0;
    if (!rst_n) begin
      m_known    = 1;
      m_busy     = 0;
      m_acc_we   = 0;
      m_last_dm  = 1;
      m_pend     = 0;
      m_mem_addr = '0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
    end else if (e_ig || e_dg) begin
      a  = e_dg ? bus.dm_addr : bus.if_addr;
      we = e_dg && bus.dm_we;
      if (we) ref_mem[a] = bus.dm_wdata;
      m_busy      = 1;
      m_last_dm   = e_dg;
      m_acc_we    = we;
      m_mem_addr  = a;
      m_acc_wdata = bus.dm_wdata;
      m_pend      = 1;
      m_pend_dm   = e_dg;
      m_pend_data = ref_mem[a];
      m_due       = cyc + 2;
    end else begin
      m_busy   = 0;
      m_acc_we = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rs, ir;
    logic [4:0] ia;
    logic       dr, dwe;
    logic [4:0] da;
    logic [7:0] dwd;
    logic       eig, edg, eir, edr, ewe;
    logic [7:0] eird, edrd;
    logic       full;
  } vec_t;

  function automatic vec_t mk(input logic rs, ir, input logic [4:0] ia,
                              input logic dr, dwe, input logic [4:0] da, input logic [7:0] dwd,
                              input logic eig, edg, eir, edr, ewe,
                              input logic [7:0] eird, edrd, input logic full);
    vec_t v;
    v.rs = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.eir = eir; v.edr = edr; v.ewe = ewe;
    v.eird = eird; v.edrd = edrd; v.full = full;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    // reset with both requesting
    tbl[0]  = mk(0, 1, 0,  1, 0, 0,  8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 1, 0,  1, 0, 0,  8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    // fetch only, addr 3
    tbl[2]  = mk(1, 1, 3,  0, 0, 0,  8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    tbl[3]  = mk(1, 0, 3,  0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    tbl[4]  = mk(1, 0, 0,  0, 0, 0,  8'h00, 0, 0, 1, 0, 0, 8'hA5, 8'h00, 1);
    // data write 3C to 31, then read back
    tbl[5]  = mk(1, 0, 0,  1, 1, 31, 8'h3C, 0, 1, 0, 0, 0, 8'hA5, 8'h00, 1);
    tbl[6]  = mk(1, 0, 0,  0, 1, 31, 8'h3C, 0, 0, 0, 0, 1, 8'hA5, 8'h00, 1);
    tbl[7]  = mk(1, 0, 0,  0, 0, 0,  8'h00, 0, 0, 0, 1, 0, 8'hA5, 8'h3C, 1);
    tbl[8]  = mk(1, 0, 0,  1, 0, 31, 8'h00, 0, 1, 0, 0, 0, 8'hA5, 8'h3C, 1);
    tbl[9]  = mk(1, 0, 0,  0, 0, 31, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 1);
    tbl[10] = mk(1, 0, 0,  0, 0, 0,  8'h00, 0, 0, 0, 1, 0, 8'hA5, 8'h3C, 1);
    // reset, then both held for six cycles
    tbl[11] = mk(0, 0, 0,  0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 1);
    tbl[12] = mk(1, 1, 3,  1, 0, 31, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    tbl[13] = mk(1, 1, 3,  1, 0, 31, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    tbl[14] = mk(1, 1, 3,  1, 0, 31, 8'h00, 0, 1, 1, 0, 0, 8'hA5, 8'h00, 1);
    tbl[15] = mk(1, 1, 3,  1, 0, 31, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h00, 1);
    tbl[16] = mk(1, 1, 3,  1, 0, 31, 8'h00, 1, 0, 0, 1, 0, 8'hA5, 8'h3C, 1);
    tbl[17] = mk(1, 1, 3,  1, 0, 31, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 1);
    tbl[18] = mk(1, 0, 0,  0, 0, 0,  8'h00, 0, 0, 1, 0, 0, 8'hA5, 8'h3C, 1);
    tbl[19] = mk(1, 0, 0,  0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 1);

    for (int r = 0; r < 20; r++) begin
      rst_n        = tbl[r].rs;
      bus.if_req   = tbl[r].ir;
      bus.if_addr  = tbl[r].ia;
      bus.dm_req   = tbl[r].dr;
      bus.dm_we    = tbl[r].dwe;
      bus.dm_addr  = tbl[r].da;
      bus.dm_wdata = tbl[r].dwd;
      tick();
      chk($sformatf("vec%0d_if_gnt", r), 32'(s_if_gnt), 32'(tbl[r].eig));
      chk($sformatf("vec%0d_dm_gnt", r), 32'(s_dm_gnt), 32'(tbl[r].edg));
      if (tbl[r].full) begin
        chk($sformatf("vec%0d_if_rvalid", r), 32'(s_if_rv), 32'(tbl[r].eir));
        chk($sformatf("vec%0d_dm_rvalid", r), 32'(s_dm_rv), 32'(tbl[r].edr));
        chk($sformatf("vec%0d_mem_we", r), 32'(s_mem_we), 32'(tbl[r].ewe));
        chk($sformatf("vec%0d_if_rdata", r), 32'(s_if_rdata), 32'(tbl[r].eird));
        chk($sformatf("vec%0d_dm_rdata", r), 32'(s_dm_rdata), 32'(tbl[r].edrd));
      end
    end

    // Write/read hazard on addr 5; IF won last, so DM writes first and IF reads the new value.
    bus.if_req = 1; bus.if_addr = 5;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 5; bus.dm_wdata = 8'h77;
    tick();
    chk("t5_dm_first", 32'(s_dm_gnt), 32'(1));
    bus.dm_req = 0;
    tick();
    tick();
    chk("t5_if_second", 32'(s_if_gnt), 32'(1));
    chk("t5_write_ack", 32'(s_dm_rv), 32'(1));
    chk("t5_write_ack_data", 32'(s_dm_rdata), 32'(8'h77));
    bus.if_req = 0;
    tick();
    tick();
    chk("t5_if_rvalid", 32'(s_if_rv), 32'(1));
    chk("t5_if_rdata", 32'(s_if_rdata), 32'(8'h77));

    // Reset during the ACCESS cycle of a DM write.
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 2; bus.dm_wdata = 8'h11;
    tick();
    chk("t6_dm_gnt", 32'(s_dm_gnt), 32'(1));
    bus.dm_req = 0;
    rst_n = 0;
    tick();
    chk("t6_mem_we_in_access", 32'(s_mem_we), 32'(1));
    rst_n = 1;
    bus.if_req = 1; bus.if_addr = 2;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 2;
    tick();
    chk("t6_no_dm_rvalid", 32'(s_dm_rv), 32'(0));
    chk("t6_dm_rdata_reset", 32'(s_dm_rdata), 32'(0));
    chk("t6_mem_committed", 32'(tb_mem[2]), 32'(8'h11));
    chk("t6_idle_if_wins_tie", 32'(s_if_gnt), 32'(1));
    bus.if_req = 0;
    tick();
    tick();
    chk("t6_if_rdata", 32'(s_if_rdata), 32'(8'h11));
    chk("t6_dm_gnt_after", 32'(s_dm_gnt), 32'(1));
    bus.dm_req = 0;
    tick();
    tick();
    chk("t6_dm_rdata", 32'(s_dm_rdata), 32'(8'h11));

    // Random traffic with request drops and occasional resets.
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if (bus.if_req && s_if_gnt) bus.if_req = 0;
      else if (bus.if_req && $urandom_range(0, 9) == 0) bus.if_req = 0;
      if (!bus.if_req && $urandom_range(0, 1) == 1) begin
        bus.if_req  = 1;
        bus.if_addr = 5'($urandom_range(0, 7));
      end
      if (bus.dm_req && s_dm_gnt) bus.dm_req = 0;
      else if (bus.dm_req && $urandom_range(0, 9) == 0) bus.dm_req = 0;
      if (!bus.dm_req && $urandom_range(0, 1) == 1) begin
        bus.dm_req   = 1;
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_addr  = 5'($urandom_range(0, 7));
        bus.dm_wdata = 8'($urandom);
      end
      tick();
      if (s_if_gnt && s_dm_gnt) chk("rand_both_gnt", 32'(1), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
